weight_tap_loader: RTL and testbench
====================================

# weight_tap_loader

Read-side sequencer for one weight buffer bank. It turns a "load N groups from address A" command into the SRAM read address, the active-low read enable and the one-hot tap-load strobes the bank consumes, so that each group of `nb_taps` consecutive buffer words lands in tap registers 0..nb_taps-1. It then holds the group for the PE array until it is acknowledged. It sits directly upstream of the bank's read port and tap registers, between the layer controller and the bank.

## Interface
- `nb_taps`, 5: taps per group; width of `weight_load_en`.
- `buffer_depth`, 72: bank SRAM depth in words.
- `buffer_addr_width`, clogb2(`buffer_depth`): SRAM address width (7 at the default depth).
- `group_cnt_width`, 8: width of `num_groups`.

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: command pulse; accepted only while idle.
- `base_addr` in `buffer_addr_width`: address of the first word; sampled when `start` is accepted.
- `num_groups` in `group_cnt_width`: number of groups to load; sampled when `start` is accepted.
- `n_ap_in` in 4: BPE approximation setting for this command; sampled when `start` is accepted.
- `taps_ack` in 1: PE array has consumed the current group.
- `rAddr` out `buffer_addr_width`: SRAM read address.
- `buffer_rEn` out 1: SRAM read enable, active-low (0 = read).
- `weight_load_en` out `nb_taps`: one-hot tap capture strobes to the bank.
- `n_ap` out 4: latched `n_ap_in`; held stable for the whole command.
- `taps_valid` out 1: all taps hold the current group.
- `busy` out 1: a command is in progress.
- `done` out 1: one-cycle pulse when the command completes.

## Operation
- **States:** IDLE, READ, SETTLE, HOLD, DONE.
- **IDLE**
  - `start`=1 latches `base_addr`, `num_groups` and `n_ap_in`.
  - Goes to READ with tap counter k=0 if `num_groups`≠0, otherwise to DONE.
- **READ**, one cycle per tap k = 0..nb_taps-1:
  - Drives `rAddr` = current address and `buffer_rEn` = 0.
  - The address then increments, wrapping from `buffer_depth`-1 to 0. Wrap is an explicit compare, not a power-of-two truncation.
  - After k = nb_taps-1, goes to SETTLE.
- **Load strobe:**
  - `weight_load_en` is a registered copy of (READ, k): bit k is high exactly in the cycle after the read of tap k. That is the cycle in which the SRAM output is valid, so the bank captures the word at the end of that cycle.
  - At most one bit is high at any time.
- **SETTLE:** one cycle; bit nb_taps-1 of the load strobe is high. Goes to HOLD.
- **HOLD**
  - `taps_valid` = 1; `buffer_rEn` = 1; `weight_load_en` = 0.
  - On `taps_ack`=1, decrement the remaining-group count. If groups remain, go to READ with k=0 and the address continuing from where it stopped. If none remain, go to DONE.
- **DONE:** `done` = 1 for one cycle, then IDLE.
- `busy` = 1 in every state except IDLE.
- `taps_ack` is ignored outside HOLD. `start` is ignored outside IDLE.
- `n_ap` changes only when a start is accepted. The bank's BPE encoder sees a constant setting throughout the command.

## Timing
- Reset values: `rAddr`=0, `buffer_rEn`=1, `weight_load_en`=0, `n_ap`=0, `taps_valid`=0, `busy`=0, `done`=0. State is IDLE.
- Start accepted at edge E0:
  - Cycle 1: `rAddr`=`base_addr`, `buffer_rEn`=0, `busy`=1.
  - Cycle 1+k: read of tap k.
  - Cycle 2+k: `weight_load_en` = 1<<k.
  - Cycle nb_taps+2: first cycle with `taps_valid`=1 (cycle 7 at the defaults).
- `taps_ack` sampled at the end of a HOLD cycle:
  - `taps_valid` drops in the next cycle.
  - If groups remain, that next cycle is the first read of the next group.
  - Otherwise that next cycle is the `done` pulse, and `busy` drops the cycle after it.
- Group-to-group minimum: nb_taps+2 cycles (acked the first cycle `taps_valid` is high); 7 at the defaults.
- `num_groups`=0: `done` in cycle 1, no reads, `busy`=1 only in cycle 1.
- `rst`=1 in any state takes priority over all inputs. Next cycle all outputs are at their reset values. Partially loaded taps are not reported valid.

## Test plan
- **Single group (defaults):** base=10, groups=1, n_ap_in=3.
  - `rAddr` = 10..14 in cycles 1-5; `weight_load_en` = 0x01,0x02,0x04,0x08,0x10 in cycles 2-6.
  - `taps_valid` from cycle 7. Ack in cycle 9 → `done` in cycle 10.
  - `n_ap`=3 throughout.
- **Wrap:** base=70, groups=1.
  - Read addresses 70, 71, 0, 1, 2.
- **Back-to-back groups:** base=0, groups=3, ack on the first valid cycle each time.
  - Reads 0-4, 5-9, 10-14.
  - `taps_valid` in cycles 7, 14, 21; `done` in cycle 22.
- **Ignored inputs:** `taps_ack` pulsed during READ, and `start` with base=40 pulsed during HOLD.
  - No state change; the ongoing command's addresses and `n_ap` are unaffected.
- **Zero groups:** start with groups=0.
  - `done` in cycle 1; `buffer_rEn` stays 1; `weight_load_en` stays 0.
- **Reset mid-load:** `rst` asserted in cycle 3 of a load.
  - Cycle 4: all outputs at reset values, IDLE.
  - A fresh start then reproduces the single-group waveform exactly.

Source files
------------

// File: rtl/weight_tap_loader_if.sv
// Command/response bundle between the layer controller, the tap loader and
// the weight bank read port.
interface weight_tap_loader_if #(
  parameter int nb_taps           = 5,
  parameter int buffer_addr_width = 7,
  parameter int group_cnt_width   = 8
);
  logic                         start;
  logic [buffer_addr_width-1:0] base_addr;
  logic [group_cnt_width-1:0]   num_groups;
  logic [3:0]                   n_ap_in;
  logic                         taps_ack;
  logic [buffer_addr_width-1:0] rAddr;
  logic                         buffer_rEn;
  logic [nb_taps-1:0]           weight_load_en;
  logic [3:0]                   n_ap;
  logic                         taps_valid;
  logic                         busy;
  logic                         done;

  modport master (
    output start, base_addr, num_groups, n_ap_in, taps_ack,
    input  rAddr, buffer_rEn, weight_load_en, n_ap, taps_valid, busy, done
  );

  modport slave (
    input  start, base_addr, num_groups, n_ap_in, taps_ack,
    output rAddr, buffer_rEn, weight_load_en, n_ap, taps_valid, busy, done
  );
endinterface

// File: rtl/weight_tap_loader.sv
// Read-side sequencer for one weight bank: streams nb_taps words per group into
// the tap registers and holds each group until the PE array acknowledges it.
module weight_tap_loader #(
  parameter int nb_taps           = 5,
  parameter int buffer_depth      = 72,
  parameter int buffer_addr_width = $clog2(buffer_depth),
  parameter int group_cnt_width   = 8
) (
  input  logic               clk,
  input  logic               rst,
  weight_tap_loader_if.slave bus
);
  localparam int kw = (nb_taps > 1) ? $clog2(nb_taps) : 1;
  localparam logic [kw-1:0]                k_last    = kw'(nb_taps - 1);
  localparam logic [buffer_addr_width-1:0] addr_last = buffer_addr_width'(buffer_depth - 1);
  localparam logic [nb_taps-1:0]           tap0      = nb_taps'(1);

  typedef enum logic [2:0] {IDLE, READ, SETTLE, HOLD, DONE} state_t;

  state_t                       state, state_n;
  logic [buffer_addr_width-1:0] addr;
  logic [kw-1:0]                k;
  logic [group_cnt_width-1:0]   grp;
  logic [3:0]                   nap_q;
  logic [nb_taps-1:0]           wle;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      addr  <= '0;
      k     <= '0;
      grp   <= '0;
      nap_q <= '0;
      wle   <= '0;
    end else begin
      state <= state_n;
      // Strobe trails the read by one cycle to line up with SRAM read data.
      wle   <= (state == READ) ? (tap0 << k) : '0;
      unique case (state)
        IDLE: if (bus.start) begin
          addr  <= bus.base_addr;
          grp   <= bus.num_groups;
          nap_q <= bus.n_ap_in;
          k     <= '0;
        end
        READ: begin
          // Depth need not be a power of two, so wrap on an explicit compare.
          addr <= (addr == addr_last) ? '0 : addr + 1'b1;
          k    <= (k == k_last) ? '0 : k + 1'b1;
        end
        HOLD: if (bus.taps_ack) grp <= grp - 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (bus.start) state_n = (bus.num_groups != '0) ? READ : DONE;
      READ:    if (k == k_last) state_n = SETTLE;
      SETTLE:  state_n = HOLD;
      HOLD:    if (bus.taps_ack)
                 state_n = (grp == group_cnt_width'(1)) ? DONE : READ;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign bus.rAddr          = addr;
  assign bus.buffer_rEn     = (state != READ);
  assign bus.weight_load_en = wle;
  assign bus.n_ap           = nap_q;
  assign bus.taps_valid     = (state == HOLD);
  assign bus.busy           = (state != IDLE);
  assign bus.done           = (state == DONE);
endmodule

// File: tb/tb_weight_tap_loader.sv
// Directed bench for weight_tap_loader: per-cycle vector table plus a
// hand-written back-to-back group sequence.
module tb_weight_tap_loader;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  weight_tap_loader_if #(.nb_taps(5), .buffer_addr_width(7), .group_cnt_width(8)) bus();
  weight_tap_loader #(.nb_taps(5), .buffer_depth(72), .group_cnt_width(8)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  // Inputs applied in this cycle; expected outputs observed in this cycle (-1 = don't care).
  typedef struct {
    int rst, start, base, groups, nap_in, ack;
    int e_addr, e_ren, e_wle, e_nap, e_valid, e_busy, e_done;
  } vec_t;

  vec_t tbl[$];
  int   errors = 0;
  int   checks = 0;

  task automatic add_row(input int r, s, b, g, n, a, ea, er, ew, en, ev, eb, ed);
    vec_t v;
    v.rst = r; v.start = s; v.base = b; v.groups = g; v.nap_in = n; v.ack = a;
    v.e_addr = ea; v.e_ren = er; v.e_wle = ew; v.e_nap = en;
    v.e_valid = ev; v.e_busy = eb; v.e_done = ed;
    tbl.push_back(v);
  endtask

  // One-group command, ack in cycle 9; noise adds an ack during READ and a start during HOLD.
  task automatic add_single(input int base, nap, prev_nap, noise);
    add_row(0, 1, base, 1, nap, 0, -1, 1, 0, prev_nap, 0, 0, 0);
    for (int c = 1; c <= 5; c++)
      add_row(0, 0, 0, 0, 0, (noise != 0 && c == 2) ? 1 : 0,
              base + c - 1, 0, (c >= 2) ? (1 << (c - 2)) : 0, nap, 0, 1, 0);
    add_row(0, 0, 0, 0, 0, 0, -1, 1, 16, nap, 0, 1, 0);
    add_row(0, 0, 0, 0, 0, 0, -1, 1, 0, nap, 1, 1, 0);
    add_row(0, noise, 40, 2, 9, 0, -1, 1, 0, nap, 1, 1, 0);
    add_row(0, 0, 0, 0, 0, 1, -1, 1, 0, nap, 1, 1, 0);
    add_row(0, 0, 0, 0, 0, 0, -1, 1, 0, nap, 0, 1, 1);
    add_row(0, 0, 0, 0, 0, 0, -1, 1, 0, nap, 0, 0, 0);
  endtask

  task automatic chk(input string nm, input int r, input int got, input int want);
    if (want < 0) return;
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s row %0d: got %0d want %0d", nm, r, got, want);
    end
  endtask

  int reads[$];
  int vcyc[$];
  int done_cyc;

  initial begin
    bus.start = 0; bus.base_addr = '0; bus.num_groups = '0; bus.n_ap_in = '0; bus.taps_ack = 0;

    // Reset state, then single group.
    add_row(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    add_single(10, 3, 0, 0);
    // Wrap at depth 72.
    add_row(0, 1, 70, 1, 0, 0, -1, 1, 0, 3, 0, 0, 0);
    add_row(0, 0, 0, 0, 0, 0, 70, 0, 0, 0, 0, 1, 0);
    add_row(0, 0, 0, 0, 0, 0, 71, 0, 1, 0, 0, 1, 0);
    add_row(0, 0, 0, 0, 0, 0,  0, 0, 2, 0, 0, 1, 0);
    add_row(0, 0, 0, 0, 0, 0,  1, 0, 4, 0, 0, 1, 0);
    add_row(0, 0, 0, 0, 0, 0,  2, 0, 8, 0, 0, 1, 0);
    add_row(0, 0, 0, 0, 0, 0, -1, 1, 16, 0, 0, 1, 0);
    add_row(0, 0, 0, 0, 0, 1, -1, 1, 0, 0, 1, 1, 0);
    add_row(0, 0, 0, 0, 0, 0, -1, 1, 0, 0, 0, 1, 1);
    add_row(0, 0, 0, 0, 0, 0, -1, 1, 0, 0, 0, 0, 0);
    // Ignored ack/start.
    add_single(10, 6, 0, 1);
    // Zero groups.
    add_row(0, 1, 20, 0, 4, 0, -1, 1, 0, 6, 0, 0, 0);
    add_row(0, 0, 0, 0, 0, 0, -1, 1, 0, 4, 0, 1, 1);
    add_row(0, 0, 0, 0, 0, 0, -1, 1, 0, 4, 0, 0, 0);
    add_row(0, 0, 0, 0, 0, 0, -1, 1, 0, 4, 0, 0, 0);
    // Reset in cycle 3, then a fresh single group.
    add_row(0, 1, 10, 1, 3, 0, -1, 1, 0, 4, 0, 0, 0);
    add_row(0, 0, 0, 0, 0, 0, 10, 0, 0, 3, 0, 1, 0);
    add_row(0, 0, 0, 0, 0, 0, 11, 0, 1, 3, 0, 1, 0);
    add_row(1, 0, 0, 0, 0, 0, 12, 0, 2, 3, 0, 1, 0);
    add_row(0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 0, 0, 0);
    add_single(10, 3, 0, 0);

    repeat (3) @(negedge clk);
    foreach (tbl[i]) begin
      @(negedge clk);
      chk("rAddr",          i, int'(bus.rAddr),          tbl[i].e_addr);
      chk("buffer_rEn",     i, int'(bus.buffer_rEn),     tbl[i].e_ren);
      chk("weight_load_en", i, int'(bus.weight_load_en), tbl[i].e_wle);
      chk("n_ap",           i, int'(bus.n_ap),           tbl[i].e_nap);
      chk("taps_valid",     i, int'(bus.taps_valid),     tbl[i].e_valid);
      chk("busy",           i, int'(bus.busy),           tbl[i].e_busy);
      chk("done",           i, int'(bus.done),           tbl[i].e_done);
      rst            = tbl[i].rst[0];
      bus.start      = tbl[i].start[0];
      bus.base_addr  = 7'(tbl[i].base);
      bus.num_groups = 8'(tbl[i].groups);
      bus.n_ap_in    = 4'(tbl[i].nap_in);
      bus.taps_ack   = tbl[i].ack[0];
    end

    // Back-to-back: three groups, each acked on its first valid cycle.
    @(negedge clk);
    bus.start = 1; bus.base_addr = 7'd0; bus.num_groups = 8'd3; bus.n_ap_in = 4'd5; bus.taps_ack = 0;
    done_cyc = 0;
    for (int cyc = 1; cyc <= 26; cyc++) begin
      @(negedge clk);
      bus.start = 0;
      if (!bus.buffer_rEn) reads.push_back(int'(bus.rAddr));
      if (bus.taps_valid) vcyc.push_back(cyc);
      if (bus.done && done_cyc == 0) done_cyc = cyc;
      if (cyc == 12) chk("b2b_n_ap", cyc, int'(bus.n_ap), 5);
      if (cyc == 23) chk("b2b_busy_drop", cyc, int'(bus.busy), 0);
      bus.taps_ack = bus.taps_valid;
    end
    bus.taps_ack = 0;
    chk("b2b_read_count", 0, reads.size(), 15);
    for (int i = 0; i < reads.size() && i < 15; i++) chk("b2b_read_addr", i, reads[i], i);
    chk("b2b_valid_count", 0, vcyc.size(), 3);
    for (int i = 0; i < vcyc.size() && i < 3; i++) chk("b2b_valid_cycle", i, vcyc[i], 7 * (i + 1));
    chk("b2b_done_cycle", 0, done_cyc, 22);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
